// File: rtl/pipe_skid_reg_if.sv
// pipe_skid_reg_if: valid/ready handshake bundle for the skid pipeline register
interface pipe_skid_reg_if #(parameter int DLEN = 32);
  logic            s_valid;
  logic            s_ready;
  logic [DLEN-1:0] s_data;
  logic            m_valid;
  logic            m_ready;
  logic [DLEN-1:0] m_data;
  logic [1:0]      occupancy;
  modport master(output s_valid, s_data, m_ready, input s_ready, m_valid, m_data, occupancy);
  modport slave(input s_valid, s_data, m_ready, output s_ready, m_valid, m_data, occupancy);
endinterface

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: elastic pipeline register with one-entry skid buffer, fully registered handshake
module pipe_skid_reg #(parameter int DLEN = 32) (
  input logic             clk,
  input logic             rst_n,
  input logic             flush,
  pipe_skid_reg_if.slave  bus
);
  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] HALF  = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;
  logic [1:0]      state, state_nxt;
  logic [DLEN-1:0] main, skid;
  logic            in_xfer, out_xfer;
  assign bus.m_valid   = state != EMPTY;
  assign bus.s_ready   = state != FULL;
  assign bus.m_data    = main;
  assign bus.occupancy = state;
  assign in_xfer       = bus.s_valid & bus.s_ready;
  assign out_xfer      = bus.m_valid & bus.m_ready;
  // next occupancy: +1 on accept-only, -1 on drain-only, unchanged otherwise
  always_comb begin
    state_nxt = state;
    if (in_xfer & ~out_xfer)
      state_nxt = state == EMPTY ? HALF : FULL;
    else if (out_xfer & ~in_xfer)
      state_nxt = state == FULL ? HALF : EMPTY;
  end
  // state and payload registers; flush empties without touching data so nothing goes X
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
      main  <= '0;
      skid  <= '0;
    end else if (flush) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
      if (in_xfer & (state == EMPTY | out_xfer))
        main <= bus.s_data;
      else if (state == FULL & out_xfer)
        main <= skid;
      if (in_xfer & state == HALF & ~out_xfer)
        skid <= bus.s_data;
    end
  end
endmodule
